logicnet_lut_layer_prog: RTL and testbench

Parametrised, registered successor to the fixed combinational LogicNet neuron ROMs. It holds one runtime-programmable truth table per neuron for a whole layer. Each table is indexed by that neuron's packed quantised inputs. Lookups flow through a valid/ready pipeline stage. After reset or on request, a clear FSM initialises every table entry. A config port lets tables be loaded without resynthesis. The block sits between consecutive layer stages of the generated network.

---
 rtl/logicnet_lut_layer_prog_pkg.sv | 26 ++
 rtl/logicnet_lut_layer_prog_if.sv | 34 +++
 rtl/logicnet_lut_table.sv | 25 ++
 rtl/logicnet_lut_layer_prog.sv | 100 ++++++++++
 tb/tb_logicnet_lut_layer_prog.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/logicnet_lut_layer_prog_pkg.sv
// Shared types and width helpers for the programmable LogicNet LUT layer.
package logicnet_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int unsigned calc_addr_w(input int unsigned fan_in, input int unsigned in_bits);
    return fan_in * in_bits;
  endfunction

  function automatic int unsigned calc_depth(input int unsigned addr_w);
    return 2 ** addr_w;
  endfunction

  function automatic int unsigned calc_nid_w(input int unsigned num_neurons);
    return (num_neurons <= 1) ? 1 : $clog2(num_neurons);
  endfunction

  // Low bit of neuron idx's field in a packed per-neuron bus.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/logicnet_lut_layer_prog_if.sv
// Lookup stream and table-config bundle for the programmable LUT layer.
interface logicnet_lut_layer_prog_if
  import logicnet_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned FAN_IN      = 3,
  parameter int unsigned IN_BITS     = 2,
  parameter int unsigned OUT_BITS    = 2
);
  localparam int unsigned ADDR_W = calc_addr_w(FAN_IN, IN_BITS);
  localparam int unsigned NID_W  = calc_nid_w(NUM_NEURONS);

  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_NEURONS*ADDR_W-1:0]   in_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_NEURONS*OUT_BITS-1:0] out_data;
  logic                            cfg_we;
  logic [NID_W-1:0]                cfg_neuron;
  logic [ADDR_W-1:0]               cfg_addr;
  logic [OUT_BITS-1:0]             cfg_data;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/logicnet_lut_table.sv
// Single-neuron truth table: one synchronous write port, asynchronous read.
module logicnet_lut_table
  import logicnet_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [OUT_BITS-1:0] wdata,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [OUT_BITS-1:0] rdata
);
  localparam int unsigned DEPTH = calc_depth(ADDR_W);

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/logicnet_lut_layer_prog.sv
// Layer of runtime-programmable neuron LUTs behind a one-stage valid/ready
// register, with a clear sweep that initialises every table entry.
module logicnet_lut_layer_prog
  import logicnet_pkg::*;
#(
  parameter int unsigned         NUM_NEURONS = 4,
  parameter int unsigned         FAN_IN      = 3,
  parameter int unsigned         IN_BITS     = 2,
  parameter int unsigned         OUT_BITS    = 2,
  parameter logic [OUT_BITS-1:0] CLEAR_VAL   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_req,
  output logic                      busy,
  logicnet_lut_layer_prog_if.slave  bus
);
  localparam int unsigned ADDR_W = calc_addr_w(FAN_IN, IN_BITS);
  localparam int unsigned DEPTH  = calc_depth(ADDR_W);
  localparam int unsigned NID_W  = calc_nid_w(NUM_NEURONS);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t                          state, state_n;
  logic [ADDR_W:0]                 cnt, cnt_n;
  logic                            sweep;
  logic                            cfg_ok;
  logic                            accept;
  logic [ADDR_W-1:0]               waddr;
  logic [OUT_BITS-1:0]             wdata;
  logic [NUM_NEURONS*OUT_BITS-1:0] lookup;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + (ADDR_W+1)'(1);
        end
      end
      RUN: begin
        if (clear_req) state_n = CLEAR;
      end
    endcase
  end

  assign sweep       = (state == CLEAR);
  assign busy        = sweep;
  assign bus.in_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
  assign accept      = bus.in_valid && bus.in_ready;
  assign cfg_ok      = (state == RUN) && bus.cfg_we && (32'(bus.cfg_neuron) < NUM_NEURONS);

  // The sweep owns every table's write port while CLEAR; config writes only in RUN.
  assign waddr = sweep ? cnt[ADDR_W-1:0] : bus.cfg_addr;
  assign wdata = sweep ? CLEAR_VAL : bus.cfg_data;

  for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
    logic we;
    assign we = sweep || (cfg_ok && (bus.cfg_neuron == NID_W'(i)));

    logicnet_lut_table #(
      .ADDR_W   (ADDR_W),
      .OUT_BITS (OUT_BITS)
    ) u_table (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (bus.in_data[slice_lo(i, ADDR_W) +: ADDR_W]),
      .rdata (lookup[slice_lo(i, OUT_BITS) +: OUT_BITS])
    );
  end

  // Async read sampled at the same edge as any write gives read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= lookup;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logicnet_lut_layer_prog.sv
// Self-checking bench for logicnet_lut_layer_prog: directed steps plus a
// randomized phase, all compared against a table-level reference model.
module tb_logicnet_lut_layer_prog;
  localparam int NN    = 4;
  localparam int AW    = 6;
  localparam int OB    = 2;
  localparam int DEPTH = 64;
  localparam logic [1:0] CV = 2'b00;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clear_req = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  logicnet_lut_layer_prog_if #(
    .NUM_NEURONS (NN), .FAN_IN (3), .IN_BITS (2), .OUT_BITS (OB)
  ) bus ();

  logicnet_lut_layer_prog #(
    .NUM_NEURONS (NN), .FAN_IN (3), .IN_BITS (2), .OUT_BITS (OB), .CLEAR_VAL (CV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .busy      (busy),
    .bus       (bus)
  );

  int unsigned total = 0, passed = 0, failed = 0;

  // Reference model: table contents, mode, sweep progress, output register.
  logic [1:0]       tbl [NN][DEPTH];
  bit               mrun = 1'b0;
  int               mcnt = 0;
  bit               mv = 1'b0;
  logic [NN*OB-1:0] md = '0;

  function automatic logic [NN*OB-1:0] ref_lookup(input logic [NN*AW-1:0] d);
    logic [NN*OB-1:0] r;
    for (int i = 0; i < NN; i++) r[i*OB +: OB] = tbl[i][d[i*AW +: AW]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wipe_model();
    for (int i = 0; i < NN; i++)
      for (int j = 0; j < DEPTH; j++) tbl[i][j] = CV;
  endtask

  // One clock cycle: drive, check combinational outputs, advance the model, check registers.
  task automatic cycle(input bit iv, input logic [NN*AW-1:0] id, input bit ordy, input bit clr,
                       input bit we, input logic [1:0] nid, input logic [AW-1:0] a,
                       input logic [OB-1:0] d);
    bit exp_rdy;
    bus.in_valid   = iv;
    bus.in_data    = id;
    bus.out_ready  = ordy;
    clear_req      = clr;
    bus.cfg_we     = we;
    bus.cfg_neuron = nid;
    bus.cfg_addr   = a;
    bus.cfg_data   = d;
    #1;
    exp_rdy = mrun && (!mv || ordy);
    chk("busy", 32'(busy), 32'(!mrun));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    if (iv && exp_rdy) begin
      mv = 1'b1;
      md = ref_lookup(id);
    end else if (ordy) begin
      mv = 1'b0;
    end
    if (we && mrun && int'(nid) < NN) tbl[nid][a] = d;
    if (!mrun) begin
      mcnt++;
      if (mcnt == DEPTH) begin
        mrun = 1'b1;
        mcnt = 0;
      end
    end else if (clr) begin
      mrun = 1'b0;
      wipe_model();
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(mv));
    chk("out_data", 32'(bus.out_data), 32'(md));
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, '0, ordy, 1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic look(input logic [NN*AW-1:0] id);
    cycle(1'b1, id, 1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic cfgw(input logic [1:0] nid, input logic [AW-1:0] a, input logic [OB-1:0] d);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, nid, a, d);
  endtask

  task automatic readback_all();
    logic [AW-1:0] av;
    for (int a = 0; a < DEPTH; a++) begin
      av = a[AW-1:0];
      look({NN{av}});
    end
    idle(1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NN*AW-1:0] d;
    logic [AW-1:0]    addrs [4];
    logic [1:0]       exps  [4];
    int               sw;

    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    wipe_model();

    // Reset values
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Initial sweep length
    sw = 0;
    while (busy && sw < 200) begin
      idle(1'b1);
      sw++;
    end
    chk("sweep1_len", 32'(sw), 32'd64);
    readback_all();

    // Program neuron 0 and stream lookups
    cfgw(2'd0, 6'b000000, 2'b10);
    cfgw(2'd0, 6'b000001, 2'b01);
    cfgw(2'd0, 6'b000010, 2'b01);
    cfgw(2'd0, 6'b000100, 2'b01);
    cfgw(2'd0, 6'b010000, 2'b01);
    addrs[0] = 6'b000000; exps[0] = 2'b10;
    addrs[1] = 6'b010000; exps[1] = 2'b01;
    addrs[2] = 6'b000011; exps[2] = 2'b00;
    addrs[3] = 6'b111111; exps[3] = 2'b00;
    for (int k = 0; k < 4; k++) begin
      d = {18'($urandom), addrs[k]};
      look(d);
      chk("n0_stream", 32'(bus.out_data[1:0]), 32'(exps[k]));
    end
    idle(1'b1);

    // Backpressure: hold 5 cycles, then accept on release
    look({18'($urandom), 6'b000000});
    for (int k = 0; k < 5; k++) cycle(1'b1, {18'($urandom), 6'b010000}, 1'b0, 1'b0, 1'b0, 2'd0, '0, '0);
    chk("bp_hold_n0", 32'(bus.out_data[1:0]), 32'(2'b10));
    cycle(1'b1, {18'($urandom), 6'b010000}, 1'b1, 1'b0, 1'b0, 2'd0, '0, '0);
    chk("bp_release_n0", 32'(bus.out_data[1:0]), 32'(2'b01));
    idle(1'b1);

    // Read-before-write collision on neuron 2, entry 0x15
    d = NN*AW'($urandom);
    d[17:12] = 6'h15;
    cycle(1'b1, d, 1'b1, 1'b0, 1'b1, 2'd2, 6'h15, 2'b11);
    chk("collision_old", 32'(bus.out_data[5:4]), 32'(2'b00));
    look(d);
    chk("collision_new", 32'(bus.out_data[5:4]), 32'(2'b11));
    idle(1'b1);

    // Clear with a held result, second clear and a config write mid-sweep
    look({18'($urandom), 6'b000000});
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 2'd0, '0, '0);
    sw = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy) break;
      if (k == 19) begin
        chk("held_valid", 32'(bus.out_valid), 32'd1);
        chk("held_n0", 32'(bus.out_data[1:0]), 32'(2'b10));
      end
      cycle(1'b1, NN*AW'($urandom), (k >= 20), (k == 5), (k == 8), 2'd1, 6'd3, 2'b11);
      sw++;
    end
    chk("sweep2_len", 32'(sw), 32'd64);
    readback_all();

    // Randomized traffic with config writes, some aimed at in-flight entries
    for (int k = 0; k < 300; k++) begin
      logic [1:0]    nid;
      logic [AW-1:0] a;
      d   = NN*AW'($urandom);
      nid = 2'($urandom);
      a   = ($urandom_range(0, 3) == 0) ? d[nid*AW +: AW] : AW'($urandom);
      cycle(1'($urandom), d, ($urandom_range(0, 3) != 0), 1'b0, ($urandom_range(0, 2) == 0),
            nid, a, 2'($urandom));
    end
    idle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
